uart_receiver: RTL and testbench

//   RS-232 8N1 receiver; counterpart of the host-link UART transmitter.

---
 rtl/uart_receiver.sv | 122 ++++++++++++
 tb/tb_uart_receiver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampling with 2-of-3 majority vote per bit.
// Optional break detection is built when UART_RX_BREAK_EN is defined.
module uart_receiver #(
  parameter int ClkFrequency = 40000000,
  parameter int Baud         = 115200,
  parameter int AccWidth     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err,
  output logic       RxD_idle,
  output logic       RxD_break
);
  localparam logic [63:0] IncWide =
    (((64'(Baud) * 64'd16) << AccWidth) + 64'(ClkFrequency) / 64'd2) / 64'(ClkFrequency);
  localparam logic [AccWidth-1:0] Inc = IncWide[AccWidth-1:0];

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t              state, state_n;
  logic [AccWidth-1:0] acc;
  logic                tick;
  logic [1:0]          sync;
  logic                rx;
  logic [3:0]          os_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shreg;
  logic                s7, s8;
  logic [7:0]          idle_cnt;
  logic                maj, decide, wrap;
  logic                start_go, load, ferr;

  // Free-running fractional accumulator; its carry is the 16x tick.
  always_ff @(posedge clk or posedge reset)
    if (reset) {tick, acc} <= '0;
    else       {tick, acc} <= {1'b0, acc} + {1'b0, Inc};

  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], RxD};

  assign rx     = sync[1];
  assign maj    = (s7 & s8) | (s7 & rx) | (s8 & rx);
  assign decide = tick && (os_cnt == 4'd9);
  assign wrap   = tick && (os_cnt == 4'd15);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;

  always_comb begin
    state_n  = state;
    start_go = 1'b0;
    load     = 1'b0;
    ferr     = 1'b0;
    case (state)
      IDLE:      if (!rx) begin state_n = START; start_go = 1'b1; end
      START:     if (decide && maj) state_n = IDLE;
                 else if (wrap)     state_n = DATA;
      DATA:      if (wrap && bit_cnt == 3'd7) state_n = STOP;
      STOP:      if (decide) begin
                   // Leave at mid-stop-bit so an early next start edge is not missed.
                   if (maj) begin state_n = IDLE;      load = 1'b1; end
                   else     begin state_n = WAIT_HIGH; ferr = 1'b1; end
                 end
      WAIT_HIGH: if (rx) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
    end else begin
      if (start_go)  os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + 4'd1;
      if (tick && os_cnt == 4'd7) s7 <= rx;
      if (tick && os_cnt == 4'd8) s8 <= rx;
      if (state == START)              bit_cnt <= '0;
      else if (state == DATA && wrap)  bit_cnt <= bit_cnt + 3'd1;
      if (state == DATA && decide)     shreg   <= {maj, shreg[7:1]};
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
    end else begin
      RxD_data_ready <= load;
      RxD_frame_err  <= ferr;
      if (load) RxD_data <= shreg;
    end

  // Saturating count of idle-high ticks; 160 ticks = 10 bit times.
  always_ff @(posedge clk or posedge reset)
    if (reset)                                   idle_cnt <= '0;
    else if (start_go)                           idle_cnt <= '0;
    else if (state == IDLE && rx && tick && idle_cnt != 8'hFF)
                                                 idle_cnt <= idle_cnt + 8'd1;

  assign RxD_idle = (idle_cnt >= 8'd160);

`ifdef UART_RX_BREAK_EN
  logic brk_zero;

  always_ff @(posedge clk or posedge reset)
    if (reset)     brk_zero <= 1'b0;
    else if (ferr) brk_zero <= (shreg == 8'h00);

  assign RxD_break = (state == WAIT_HIGH) && brk_zero && !rx;
`else
  assign RxD_break = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed 8N1 cases plus random byte streams.
module tb_uart_receiver;
  localparam int BitClk = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] RxD_data;
  logic       RxD_data_ready, RxD_frame_err, RxD_idle, RxD_break;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         err_pending = 0;
  logic [7:0] model_data = 8'h00;
  logic       prev_ready = 1'b0;
  logic [7:0] e;
  bit         brk_exp;

  uart_receiver #(.ClkFrequency(7372800), .Baud(115200), .AccWidth(16)) dut (
    .clk(clk), .reset(reset), .RxD(RxD),
    .RxD_data(RxD_data), .RxD_data_ready(RxD_data_ready),
    .RxD_frame_err(RxD_frame_err), .RxD_idle(RxD_idle), .RxD_break(RxD_break)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: start, 8 data bits LSB first, stop; optional 1-clk glitch in data bit 3.
  task automatic send(input logic [7:0] b, input bit stop_bit, input bit glitch);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    if (stop_bit) exp_q.push_back(b);
    else          err_pending++;
    for (int i = 0; i < 10; i++) begin
      RxD = f[i];
      if (glitch && i == 4) begin
        wait_clk(34); RxD = ~f[i];
        wait_clk(1);  RxD = f[i];
        wait_clk(BitClk - 35);
      end else begin
        wait_clk(BitClk);
      end
    end
    RxD = 1'b1;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_pending != 0) && n < 3000) begin
      wait_clk(1);
      n++;
    end
    check("drain_bytes", exp_q.size(), 0);
    check("drain_errs", err_pending, 0);
  endtask

  // Monitor: every strobe must match the next expectation in order.
  always @(negedge clk) begin
    if (reset) begin
      prev_ready = 1'b0;
    end else begin
      if (RxD_data_ready) begin
        check("ready_one_cycle", prev_ready, 0);
        check("ready_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rx_byte", RxD_data, e);
          model_data = e;
        end
      end
      if (RxD_frame_err) begin
        check("frame_err_expected", err_pending > 0, 1);
        check("data_hold_on_err", RxD_data, model_data);
        if (err_pending > 0) err_pending--;
      end
      prev_ready = RxD_data_ready;
    end
  end

  initial begin
`ifdef UART_RX_BREAK_EN
    brk_exp = 1'b1;
`else
    brk_exp = 1'b0;
`endif
    wait_clk(3);
    check("rst_data", RxD_data, 0);
    check("rst_ready", RxD_data_ready, 0);
    check("rst_ferr", RxD_frame_err, 0);
    check("rst_idle", RxD_idle, 0);
    check("rst_break", RxD_break, 0);
    reset = 1'b0;
    wait_clk(200);
    check("idle_not_yet", RxD_idle, 0);
    wait_clk(500);
    check("idle_after_10_bits", RxD_idle, 1);

    // 1: single byte
    send(8'h55, 1'b1, 1'b0);
    wait_clk(100);
    drain();
    check("t1_data", RxD_data, 8'h55);

    // 2: back-to-back frames
    send(8'hA5, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    wait_clk(100);
    drain();

    // 3: false start pulse, then a real byte
    RxD = 1'b0; wait_clk(20); RxD = 1'b1;
    wait_clk(200);
    check("t3_no_strobe_data", RxD_data, 8'h3C);
    send(8'h81, 1'b1, 1'b0);
    wait_clk(100);
    drain();

    // 4: glitch rejected by majority vote
    send(8'h00, 1'b1, 1'b1);
    wait_clk(100);
    drain();
    check("t4_data", RxD_data, 8'h00);

    // 5: framing error and break
    send(8'hFF, 1'b1, 1'b0);
    wait_clk(100);
    drain();
    send(8'h00, 1'b0, 1'b0);
    RxD = 1'b0;
    wait_clk(100);
    check("t5_break_active", RxD_break, brk_exp);
    check("t5_data_held", RxD_data, 8'hFF);
    wait_clk(100);
    RxD = 1'b1;
    wait_clk(4);
    check("t5_break_cleared", RxD_break, 0);
    drain();
    wait_clk(200);

    // 6: reset in the middle of 0x3C
    RxD = 1'b0; wait_clk(BitClk);
    for (int i = 0; i < 4; i++) begin
      RxD = 8'h3C >> i; wait_clk(BitClk);
    end
    RxD = 1'b1; wait_clk(30);
    reset = 1'b1;
    model_data = 8'h00;
    wait_clk(2);
    check("t6_rst_data", RxD_data, 0);
    check("t6_rst_ready", RxD_data_ready, 0);
    check("t6_rst_idle", RxD_idle, 0);
    check("t6_rst_break", RxD_break, 0);
    reset = 1'b0;
    wait_clk(700);
    check("t6_idle", RxD_idle, 1);
    fork
      send(8'hF0, 1'b1, 1'b0);
      begin wait_clk(200); check("idle_clears_in_frame", RxD_idle, 0); end
    join
    wait_clk(100);
    drain();

    // Random bytes, random gaps (gap 0 = back-to-back), occasional bad stop bit.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rb;
      bit         good;
      rb   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      send(rb, good, 1'b0);
      if (!good) begin
        RxD = 1'b0; wait_clk(20); RxD = 1'b1; wait_clk(80);
      end
      wait_clk($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 40));
    end
    wait_clk(200);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
